// File: rtl/ram_port_arbiter_if.sv
// Bundle of requester-side and RAM-side signals for ram_port_arbiter.
// Ports: slave = arbiter view, master = requesters + RAM view.
interface ram_port_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8
);
    logic                      interrupt;
    logic [NUM_REQ-1:0]        reqRead;
    logic [NUM_REQ-1:0]        reqWrite;
    logic [NUM_REQ*ADDR_W-1:0] reqAddr;
    logic [NUM_REQ*DATA_W-1:0] reqWData;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        reqDone;
    logic                      reqError;
    logic [DATA_W-1:0]         reqRData;
    logic [ADDR_W-1:0]         ramAddress;
    logic [DATA_W-1:0]         ramDataIn;
    logic                      ramReadSignal;
    logic                      ramWriteSignal;
    logic [DATA_W-1:0]         ramDataOut;
    logic                      ramDoneRead;
    logic                      ramDoneWrite;
    logic                      busy;

    modport slave (
        input  interrupt, reqRead, reqWrite, reqAddr, reqWData,
        input  ramDataOut, ramDoneRead, ramDoneWrite,
        output grant, reqDone, reqError, reqRData,
        output ramAddress, ramDataIn, ramReadSignal, ramWriteSignal,
        output busy
    );

    modport master (
        output interrupt, reqRead, reqWrite, reqAddr, reqWData,
        output ramDataOut, ramDoneRead, ramDoneWrite,
        input  grant, reqDone, reqError, reqRData,
        input  ramAddress, ramDataIn, ramReadSignal, ramWriteSignal,
        input  busy
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between NUM_REQ requesters.
// Ports: clk, RST (async, active high), bus (slave modport: requests,
// grant/done/error/rdata, RAM strobes/address/data, RAM done, busy).
module ram_port_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             RST,
    ram_port_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t             state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   owner;
    logic               is_write;
    logic [CNT_W-1:0]   age;

    logic [NUM_REQ-1:0] req;
    logic               found;
    logic [PTR_W-1:0]   pick;
    logic               pick_wr;
    logic [ADDR_W-1:0]  pick_addr;
    logic [DATA_W-1:0]  pick_data;
    logic               hit;

    assign req = bus.reqRead | bus.reqWrite;
    assign hit = is_write ? bus.ramDoneWrite : bus.ramDoneRead;

    // Scan requesters starting just after the last winner, wrapping.
    // The outer loop walks priority order; the inner loop maps a
    // priority slot back to a constant requester index.
    always_comb begin
        found     = 1'b0;
        pick      = '0;
        pick_wr   = 1'b0;
        pick_addr = '0;
        pick_data = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!found && req[j] &&
                    j == (int'(rr_ptr) + i) % NUM_REQ) begin
                    found     = 1'b1;
                    pick      = PTR_W'(j);
                    pick_wr   = bus.reqWrite[j];
                    pick_addr = bus.reqAddr[j*ADDR_W +: ADDR_W];
                    pick_data = bus.reqWData[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state              <= IDLE;
            rr_ptr             <= PTR_W'(NUM_REQ - 1);
            owner              <= '0;
            is_write           <= 1'b0;
            age                <= '0;
            bus.grant          <= '0;
            bus.reqDone        <= '0;
            bus.reqError       <= 1'b0;
            bus.reqRData       <= '0;
            bus.ramAddress     <= '0;
            bus.ramDataIn      <= '0;
            bus.ramReadSignal  <= 1'b0;
            bus.ramWriteSignal <= 1'b0;
            bus.busy           <= 1'b0;
        end else begin
            bus.reqDone  <= '0;
            bus.reqError <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!bus.interrupt && found) begin
                        owner              <= pick;
                        is_write           <= pick_wr;
                        age                <= '0;
                        bus.grant          <= NUM_REQ'(1) << pick;
                        bus.ramAddress     <= pick_addr;
                        bus.ramDataIn      <= pick_data;
                        // Write wins when both read and write are asked.
                        bus.ramReadSignal  <= !pick_wr;
                        bus.ramWriteSignal <= pick_wr;
                        bus.busy           <= 1'b1;
                        state              <= WAIT;
                    end
                end
                WAIT: begin
                    if (hit || age == CNT_W'(TIMEOUT - 1)) begin
                        if (hit && !is_write) begin
                            bus.reqRData <= bus.ramDataOut;
                        end
                        bus.reqError       <= !hit;
                        bus.reqDone        <= NUM_REQ'(1) << owner;
                        rr_ptr             <= owner;
                        bus.grant          <= '0;
                        bus.ramAddress     <= '0;
                        bus.ramDataIn      <= '0;
                        bus.ramReadSignal  <= 1'b0;
                        bus.ramWriteSignal <= 1'b0;
                        bus.busy           <= 1'b0;
                        state              <= IDLE;
                    end else begin
                        age <= age + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: transaction-level model,
// per-cycle compare, and directed scenarios with literal expectations.
module tb_ram_port_arbiter;
    localparam int NR = 3;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic RST = 1'b0;

    ram_port_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus();

    ram_port_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .RST(RST),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // RAM responder: done after ram_lat strobe cycles (0 = never).
    int         ram_lat   = 0;
    int         scnt      = 0;
    logic       auto_done = 1'b0;
    logic       man_rd    = 1'b0;
    logic       man_wr    = 1'b0;
    logic [7:0] ram_rdata = 8'h00;

    assign bus.ramDoneRead  = (auto_done & bus.ramReadSignal) | man_rd;
    assign bus.ramDoneWrite = (auto_done & bus.ramWriteSignal) | man_wr;
    assign bus.ramDataOut   = ram_rdata;

    always begin
        @(posedge clk);
        cyc++;
        #1;
        if (RST || !(bus.ramReadSignal || bus.ramWriteSignal)) scnt = 0;
        else scnt++;
        auto_done = (ram_lat > 0) && (scnt >= ram_lat);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: who owns the port, what it asked for,
    // how many strobe cycles it has used, and the last completion.
    int         m_owner = -1;
    int         m_ptr   = NR - 1;
    bit         m_wr    = 1'b0;
    logic [15:0] m_addr = '0;
    logic [7:0] m_data  = '0;
    logic [7:0] m_rdata = '0;
    int         m_used  = 0;
    int         m_done  = -1;
    bit         m_err   = 1'b0;

    always @(posedge clk or posedge RST) begin
        if (RST) begin
            m_owner = -1;
            m_ptr   = NR - 1;
            m_rdata = '0;
            m_done  = -1;
            m_err   = 1'b0;
            m_used  = 0;
        end else begin
            m_done = -1;
            m_err  = 1'b0;
            if (m_owner < 0) begin
                if (!bus.interrupt) begin
                    int rq;
                    rq = int'(bus.reqRead | bus.reqWrite);
                    for (int k = 1; k <= NR; k++) begin
                        int c;
                        c = (m_ptr + k) % NR;
                        if (m_owner < 0 && ((rq >> c) & 1) != 0) begin
                            m_owner = c;
                            m_wr    = ((int'(bus.reqWrite) >> c) & 1) != 0;
                            m_addr  = 16'(bus.reqAddr >> (c * AW));
                            m_data  = 8'(bus.reqWData >> (c * DW));
                            m_used  = 0;
                        end
                    end
                end
            end else begin
                bit ok;
                m_used++;
                ok = m_wr ? bus.ramDoneWrite : bus.ramDoneRead;
                if (ok || m_used == TO) begin
                    if (ok && !m_wr) m_rdata = bus.ramDataOut;
                    m_err   = !ok;
                    m_done  = m_owner;
                    m_ptr   = m_owner;
                    m_owner = -1;
                end
            end
        end
    end

    always @(negedge clk) begin
        int eg, es, eb, ed;
        eg = (m_owner >= 0) ? (1 << m_owner) : 0;
        es = (m_owner >= 0) ? {29'd0, !m_wr, m_wr, 1'b1} : 0;
        eb = (m_owner >= 0) ? {8'd0, m_addr, m_data} : 0;
        ed = (m_done >= 0) ? ((1 << m_done) << 1) | int'(m_err) : 0;
        check("grant", 32'(bus.grant), eg);
        check("strobe_busy", 32'({bus.ramReadSignal, bus.ramWriteSignal,
              bus.busy}), es);
        check("addr_data", 32'({bus.ramAddress, bus.ramDataIn}), eb);
        check("done_err", 32'({bus.reqDone, bus.reqError}), ed);
        check("rdata", 32'(bus.reqRData), 32'(m_rdata));
    end

    task automatic wait_done(input int idx, input string name);
        int w;
        w = 0;
        while (((int'(bus.reqDone) >> idx) & 1) == 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check(name, (int'(bus.reqDone) >> idx) & 1, 1);
    endtask

    initial begin
        int order[$];
        int ndone, w, sc, anyg;
        logic [2:0] prevg;

        bus.interrupt = 1'b0;
        bus.reqRead   = '0;
        bus.reqWrite  = '0;
        bus.reqAddr   = '0;
        bus.reqWData  = '0;
        RST = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_grant", 32'(bus.grant), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_rdata", 32'(bus.reqRData), 0);
        RST = 1'b0;

        // Round robin, all requesting, RAM answers in first strobe cycle.
        ram_lat = 1;
        bus.reqAddr = {16'h0300, 16'h0200, 16'h0100};
        bus.reqRead = 3'b111;
        ndone = 0;
        prevg = '0;
        for (int k = 0; k < 60 && ndone < 6; k++) begin
            @(negedge clk);
            if (bus.grant != 0 && prevg == 0) order.push_back($clog2(bus.grant));
            prevg = bus.grant;
            if (bus.reqDone != 0) ndone++;
        end
        bus.reqRead = '0;
        check("rr_dones", ndone, 6);
        check("rr_len", order.size(), 6);
        if (order.size() == 6) begin
            for (int i = 0; i < 6; i++) check("rr_order", order[i], i % 3);
        end

        // Single read by requester 1.
        ram_lat = 3;
        ram_rdata = 8'hA5;
        bus.reqAddr[AW +: AW] = 16'h1234;
        bus.reqRead[1] = 1'b1;
        @(negedge clk);
        check("rd_grant", 32'(bus.grant), 2);
        check("rd_addr", 32'(bus.ramAddress), 'h1234);
        check("rd_strobe", 32'(bus.ramReadSignal), 1);
        w = 0;
        while (!bus.reqDone[1] && w < 30) begin
            @(negedge clk);
            w++;
        end
        check("rd_done", 32'(bus.reqDone), 2);
        check("rd_latency", w, 3);
        check("rd_data", 32'(bus.reqRData), 'hA5);
        check("rd_strobe_low", 32'(bus.ramReadSignal), 0);
        bus.reqRead[1] = 1'b0;

        // Write wins over read; read-done is ignored; latched values hold.
        ram_lat = 0;
        bus.reqAddr[0 +: AW] = 16'h0010;
        bus.reqWData[0 +: DW] = 8'h3C;
        bus.reqRead[0] = 1'b1;
        bus.reqWrite[0] = 1'b1;
        @(negedge clk);
        check("wr_wstrobe", 32'(bus.ramWriteSignal), 1);
        check("wr_rstrobe", 32'(bus.ramReadSignal), 0);
        check("wr_din", 32'(bus.ramDataIn), 'h3C);
        check("wr_addr", 32'(bus.ramAddress), 'h0010);
        man_rd = 1'b1;
        @(negedge clk);
        man_rd = 1'b0;
        check("wr_ign_rd", 32'({bus.grant, bus.reqDone}), 'b001000);
        bus.reqAddr[0 +: AW] = 16'hFFFF;
        bus.reqWData[0 +: DW] = 8'h00;
        @(negedge clk);
        check("wr_latched", 32'({bus.ramAddress, bus.ramDataIn}), 'h00103C);
        man_wr = 1'b1;
        @(negedge clk);
        man_wr = 1'b0;
        check("wr_done", 32'({bus.reqDone, bus.reqError}), 'b0010);
        check("wr_rdata_kept", 32'(bus.reqRData), 'hA5);
        bus.reqRead[0] = 1'b0;
        bus.reqWrite[0] = 1'b0;

        // Timeout: RAM silent, strobe for exactly TIMEOUT cycles.
        ram_lat = 0;
        bus.reqAddr[2*AW +: AW] = 16'h0200;
        bus.reqRead[2] = 1'b1;
        sc = 0;
        w = 0;
        while (!bus.reqDone[2] && w < 100) begin
            @(negedge clk);
            w++;
            if (bus.ramReadSignal) sc++;
        end
        check("to_strobe_cycles", sc, 64);
        check("to_done", 32'({bus.reqDone, bus.reqError}), 'b1001);
        check("to_rdata_kept", 32'(bus.reqRData), 'hA5);
        bus.reqRead[2] = 1'b0;
        @(negedge clk);
        check("to_idle", 32'(bus.busy), 0);

        // Interrupt raised while requester 2 is in flight.
        ram_lat = 3;
        bus.reqAddr[2*AW +: AW] = 16'h0222;
        bus.reqRead[2] = 1'b1;
        @(negedge clk);
        check("int_grant2", 32'(bus.grant), 4);
        bus.interrupt = 1'b1;
        bus.reqAddr[0 +: AW] = 16'h0005;
        bus.reqRead[0] = 1'b1;
        ram_rdata = 8'h5A;
        wait_done(2, "int_done2");
        bus.reqRead[2] = 1'b0;
        check("int_rdata", 32'(bus.reqRData), 'h5A);
        anyg = 0;
        repeat (5) begin
            @(negedge clk);
            anyg = anyg | int'(bus.grant);
        end
        check("int_hold", anyg, 0);
        bus.interrupt = 1'b0;
        @(negedge clk);
        check("int_release", 32'(bus.grant), 1);
        wait_done(0, "int_done0");
        bus.reqRead[0] = 1'b0;

        // Asynchronous reset in the middle of a transaction.
        ram_lat = 0;
        bus.reqAddr[AW +: AW] = 16'h0111;
        bus.reqRead[1] = 1'b1;
        @(negedge clk);
        check("ar_grant", 32'(bus.grant), 2);
        @(posedge clk);
        #2;
        RST = 1'b1;
        #1;
        check("ar_grant_drop", 32'(bus.grant), 0);
        check("ar_strobe_drop", 32'({bus.ramReadSignal, bus.ramWriteSignal,
              bus.busy}), 0);
        bus.reqRead[0] = 1'b1;
        @(negedge clk);
        check("ar_no_done", 32'(bus.reqDone), 0);
        RST = 1'b0;
        ram_lat = 1;
        @(negedge clk);
        check("ar_first", 32'(bus.grant), 1);
        wait_done(0, "ar_done0");
        bus.reqRead[0] = 1'b0;
        wait_done(1, "ar_done1");
        bus.reqRead[1] = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
